// File: rtl/pulse_train_gen.sv
// Moore pulse-train generator: on an accepted start, emits `count` high pulses of
// latched high/low widths on x_out, then raises done for one cycle.
module pulse_train_gen #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] count,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  output logic             x_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q,  state_d;
  logic [LEN_W-1:0] phase_q,  phase_d;
  logic [LEN_W-1:0] high_q,   high_d;
  logic [LEN_W-1:0] low_q,    low_d;
  logic [CNT_W-1:0] pulses_q, pulses_d;
  logic [LEN_W-1:0] high_eff, low_eff;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    high_d   = high_q;
    low_d    = low_q;
    pulses_d = pulses_q;
    // A zero length would otherwise collapse a phase; treat it as one cycle.
    high_eff = (high_len == '0) ? LEN_W'(1) : high_len;
    low_eff  = (low_len  == '0) ? LEN_W'(1) : low_len;

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              state_d = DONE;
            end else begin
              pulses_d = count;
              high_d   = high_eff;
              low_d    = low_eff;
              phase_d  = high_eff - LEN_W'(1);
              state_d  = HIGH;
            end
          end
        end
        HIGH: begin
          if (phase_q == '0) begin
            pulses_d = pulses_q - CNT_W'(1);
            // Last pulse goes straight to DONE with no trailing gap.
            if (pulses_q == CNT_W'(1)) begin
              state_d = DONE;
            end else begin
              phase_d = low_q - LEN_W'(1);
              state_d = LOW;
            end
          end else begin
            phase_d = phase_q - LEN_W'(1);
          end
        end
        LOW: begin
          if (phase_q == '0) begin
            phase_d = high_q - LEN_W'(1);
            state_d = HIGH;
          end else begin
            phase_d = phase_q - LEN_W'(1);
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      high_q   <= '0;
      low_q    <= '0;
      pulses_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      high_q   <= high_d;
      low_q    <= low_d;
      pulses_q <= pulses_d;
    end
  end

  assign x_out = (state_q == HIGH);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: the driver queues the expected {x_out,busy,done}
// for the cycle after each edge; a negedge monitor pops and compares.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] count = '0;
  logic [7:0] high_len = '0;
  logic [7:0] low_len = '0;
  logic       x_out, busy, done;

  typedef struct {
    string      name;
    logic [2:0] exp;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    rise_cnt = 0;
  string test_name = "reset";

  pulse_train_gen #(.CNT_W(8), .LEN_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .count(count), .high_len(high_len), .low_len(low_len),
    .x_out(x_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: x/busy/done got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs for one cycle and queue the outputs expected after the next edge.
  task automatic cyc(input logic s, input logic a, input logic [7:0] c,
                     input logic [7:0] h, input logic [7:0] l, input logic [2:0] e);
    exp_t item;
    @(negedge clk);
    #1;
    start = s; abort = a; count = c; high_len = h; low_len = l;
    item.name = test_name;
    item.exp  = e;
    exp_q.push_back(item);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      checks++;
      $display("FAIL drain_%s: %0d entries left expected 0", test_name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor
  initial begin
    logic prev_x = 1'b0;
    exp_t item;
    forever begin
      @(negedge clk);
      if (x_out && !prev_x) rise_cnt++;
      prev_x = x_out;
      if (exp_q.size() != 0) begin
        item = exp_q.pop_front();
        check(item.name, {x_out, busy, done}, item.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    logic [2:0] basic [10] = '{3'b110, 3'b110, 3'b010, 3'b110, 3'b110,
                               3'b010, 3'b110, 3'b110, 3'b011, 3'b000};

    // Reset then 10 quiet cycles
    #12 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 3'b000);
    drain();

    // Basic train N=3 H=2 L=1; inputs cleared after acceptance
    test_name = "basic";
    snap = rise_cnt;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) cyc(1, 0, 3, 2, 1, basic[i]);
      else        cyc(0, 0, 0, 0, 0, basic[i]);
    end
    drain();
    check_int("basic_rises", rise_cnt - snap, 3);

    // Zero lengths map to 1
    test_name = "zero_map";
    snap = rise_cnt;
    cyc(1, 0, 2, 0, 0, 3'b110);
    cyc(0, 0, 0, 0, 0, 3'b010);
    cyc(0, 0, 0, 0, 0, 3'b110);
    cyc(0, 0, 0, 0, 0, 3'b011);
    cyc(0, 0, 0, 0, 0, 3'b000);
    drain();
    check_int("zero_map_rises", rise_cnt - snap, 2);

    // Zero count, start during DONE ignored, start in first IDLE cycle accepted
    test_name = "zero_count";
    cyc(1, 0, 0, 5, 5, 3'b011);
    cyc(1, 0, 1, 1, 1, 3'b000);
    cyc(1, 0, 1, 1, 1, 3'b110);
    cyc(0, 0, 0, 0, 0, 3'b011);
    cyc(0, 0, 0, 0, 0, 3'b000);
    drain();

    // Busy start ignored, abort kills train, fresh start afterwards
    test_name = "abort";
    cyc(1, 0, 5, 3, 2, 3'b110);
    cyc(0, 0, 0, 0, 0, 3'b110);
    cyc(0, 0, 0, 0, 0, 3'b110);
    cyc(0, 0, 0, 0, 0, 3'b010);
    cyc(1, 0, 5, 3, 2, 3'b010);
    cyc(0, 0, 0, 0, 0, 3'b110);
    cyc(0, 1, 0, 0, 0, 3'b000);
    cyc(0, 0, 0, 0, 0, 3'b000);
    cyc(1, 0, 2, 1, 1, 3'b110);
    cyc(0, 0, 0, 0, 0, 3'b010);
    cyc(0, 0, 0, 0, 0, 3'b110);
    cyc(0, 0, 0, 0, 0, 3'b011);
    cyc(0, 0, 0, 0, 0, 3'b000);
    drain();

    // Abort with start in IDLE: start wins
    test_name = "abort_idle";
    cyc(1, 1, 1, 1, 1, 3'b110);
    cyc(0, 0, 0, 0, 0, 3'b011);
    cyc(0, 0, 0, 0, 0, 3'b000);
    drain();

    // Async reset in the middle of a high phase
    test_name = "async_reset";
    cyc(1, 0, 3, 4, 1, 3'b110);
    cyc(0, 0, 0, 0, 0, 3'b110);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset_drop", {x_out, busy, done}, 3'b000);
    #3 reset_n = 1'b1;
    test_name = "post_reset";
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 3'b000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Moore-style pulse-train generator: on a one-cycle `start` request, it drives a programmable number of clean high pulses onto `x_out`, with programmable high and low widths, then flags completion. It is the source end of our positive-edge-detection path. It produces the level waveform that a downstream edge detector consumes, and is used both as a stimulus driver and as a functional pulse emitter. Every pulse is guaranteed to be separated by at least one low cycle, so each pulse yields exactly one rising edge.

## Interface

Parameters:
- `CNT_W`, default 8: width of the pulse-count input.
- `LEN_W`, default 8: width of the high/low phase-length inputs.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request pulse; sampled only in IDLE.
- `abort`, input, 1: synchronous cancel; effective in any non-IDLE state.
- `count`, input, CNT_W: number of pulses; latched on accepted `start`.
- `high_len`, input, LEN_W: cycles per high phase; latched on `start`; 0 is treated as 1.
- `low_len`, input, LEN_W: cycles per low gap; latched on `start`; 0 is treated as 1.
- `x_out`, output, 1: generated pulse train.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle completion pulse.

## Operation

- States: IDLE, HIGH, LOW, DONE. Outputs are decoded purely from the state register (Moore):
  - `x_out` = (state == HIGH).
  - `busy` = (state != IDLE).
  - `done` = (state == DONE).
- **Reset.** State goes to IDLE. All counters and latched values go to 0. Outputs: `x_out`=0, `busy`=0, `done`=0.
- **IDLE.**
  - `start`=1 and `count`≠0: latch `count`, max(`high_len`,1) and max(`low_len`,1). Load the phase counter. Go to HIGH.
  - `start`=1 and `count`=0: go to DONE directly; no pulse is emitted.
  - Otherwise stay in IDLE.
- **HIGH.**
  - The phase counter counts the latched high length.
  - At the final high cycle, decrement the remaining-pulse counter.
  - If pulses remain, go to LOW; otherwise go to DONE.
- **LOW.** The phase counter counts the latched low length. At the final low cycle, go to HIGH and reload the high length.
- **DONE.** Lasts exactly one cycle, then go to IDLE unconditionally.
- **`abort`.**
  - In HIGH, LOW or DONE, `abort`=1 forces IDLE on the next edge. `done` is not asserted for an aborted train.
  - `abort` has priority over all other transitions.
  - `abort` in IDLE is ignored. If `abort` and `start` are both high in IDLE, the `start` is accepted.
- `start` outside IDLE is ignored and is not queued.
- Inputs `count`, `high_len` and `low_len` may change freely after acceptance; only the latched copies are used.
- Counters are unsigned.
  - The phase counter is LEN_W bits wide and never wraps: it is loaded with len−1 and counts down to 0.
  - The pulse counter is CNT_W bits wide. The maximum is `count`=2^CNT_W−1 pulses.
- Asserting `reset_n` low mid-train drops `x_out` asynchronously. No `done` is produced.

## Timing

- `start` is accepted at edge 0. `x_out` rises after edge 0 (cycle 1); this is one cycle of latency. `busy` rises in the same cycle.
- Each high phase lasts exactly H cycles and each low gap exactly L cycles, where H and L are the latched lengths after the 0→1 mapping.
- There is no low gap after the final pulse. DONE immediately follows the last high cycle. During DONE, `x_out`=0, `done`=1 and `busy`=1.
- Total busy duration for N≥1 pulses is N·H + (N−1)·L + 1 cycles. For N=0 it is 1 cycle.
- A new `start` can be accepted in the first IDLE cycle after DONE, which is the earliest point.
- `abort` sampled at edge k gives `x_out`=0 and `busy`=0 from cycle k+1.

## Test plan

- **Reset.** Apply reset, then release it with `start`=0. Required: `x_out`=0, `busy`=0, `done`=0, holding steady for 10 cycles.
- **Basic train.** `count`=3, `high_len`=2, `low_len`=1, `start` at cycle 0.
  - `x_out` is high in cycles 1–2, 4–5 and 7–8, and low in cycles 3 and 6.
  - `done`=1 only in cycle 9. `busy` covers cycles 1–9.
  - Exactly 3 rising edges.
- **Zero mapping.** `count`=2, `high_len`=0, `low_len`=0.
  - `x_out` is high in cycles 1 and 3 and low in cycle 2. `done` in cycle 4.
  - With a positive-edge detector attached, it pulses twice.
- **Zero count.** `count`=0 with `start`: `done` and `busy` in cycle 1 only; `x_out` stays 0.
- **Abort and busy start.**
  - `count`=5, `high_len`=3, `low_len`=2. A second `start` in cycle 4 is ignored. `abort` in cycle 6 gives `x_out`=`busy`=0 from cycle 7, with no `done`.
  - A new `start` in cycle 8 begins a fresh train in cycle 9.
- **Async reset mid-train.** Pull `reset_n` low during a HIGH phase. `x_out` drops within the same cycle with no clock edge. After release, the block stays in IDLE until the next `start`.
